// File: rtl/accel_core.sv
// Weight-stationary inference core: xmem -> L0 -> dot-product array -> OFIFO -> pmem -> accumulator.
// Build option: define ACCEL_CORE_RELU_EN to clamp negative accumulator lanes to zero on coreOut.

module accel_core_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !reset) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module accel_core #(
    parameter int row     = 8,
    parameter int col     = 8,
    parameter int bw      = 4,
    parameter int psum_bw = 16,
    parameter int num     = 2048
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [33:0]            inst,
    input  logic [bw*row-1:0]      D_xmem,
    output logic                   valid,
    output logic [col*psum_bw-1:0] coreOut
);
    localparam int WPTR_W = $clog2(col);

    // Instruction decode
    logic        acc;
    logic        cen_pmem;
    logic        wen_pmem;
    logic [10:0] a_pmem;
    logic        cen_xmem;
    logic        wen_xmem;
    logic [10:0] a_xmem;
    logic        ofifo_rd;
    logic        ififo_wr;
    logic        ififo_rd;
    logic        l0_rd;
    logic        l0_wr;
    logic        execute;
    logic        load;

    assign acc      = inst[33];
    assign cen_pmem = inst[32];
    assign wen_pmem = inst[31];
    assign a_pmem   = inst[30:20];
    assign cen_xmem = inst[19];
    assign wen_xmem = inst[18];
    assign a_xmem   = inst[17:7];
    assign ofifo_rd = inst[6];
    assign ififo_wr = inst[5];
    assign ififo_rd = inst[4];
    assign l0_rd    = inst[3];
    assign l0_wr    = inst[2];
    assign execute  = inst[1];
    assign load     = inst[0];

    // Activation SRAM
    logic [bw*row-1:0] xmem [num];
    logic [bw*row-1:0] xmem_q;

    always_ff @(posedge clk) begin
        if (!reset && !cen_xmem && !wen_xmem) begin
            xmem[a_xmem] <= D_xmem;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            xmem_q <= '0;
        end else if (!cen_xmem && wen_xmem) begin
            xmem_q <= xmem[a_xmem];
        end
    end

    // L0 activation FIFO and weight input FIFO
    logic [bw*row-1:0] l0_dout;
    logic              l0_empty;
    logic [bw*row-1:0] ififo_dout;
    logic              ififo_empty;

    accel_core_fifo #(.W(bw*row), .DEPTH(16)) u_l0 (
        .clk   (clk),
        .reset (reset),
        .push  (l0_wr),
        .pop   (l0_rd),
        .din   (xmem_q),
        .dout  (l0_dout),
        .empty (l0_empty)
    );

    accel_core_fifo #(.W(bw*row), .DEPTH(16)) u_ififo (
        .clk   (clk),
        .reset (reset),
        .push  (ififo_wr),
        .pop   (ififo_rd),
        .din   (D_xmem),
        .dout  (ififo_dout),
        .empty (ififo_empty)
    );

    // Weight registers: w[c] lane r holds weight (row r, column c)
    logic [bw*row-1:0] w [col];
    logic [WPTR_W-1:0] wptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < col; c++) begin
                w[c] <= '0;
            end
            wptr <= '0;
        end else if (load && ififo_rd && !ififo_empty) begin
            w[wptr] <= ififo_dout;
            wptr    <= wptr + WPTR_W'(1);
        end
    end

    // Dot-product array: unsigned activations times signed weights, wrapping at psum_bw
    logic [col*psum_bw-1:0]    dot_word;
    logic signed [psum_bw-1:0] a_ext;
    logic signed [psum_bw-1:0] w_ext;
    logic signed [psum_bw-1:0] lane_sum;

    always_comb begin
        dot_word = '0;
        a_ext    = '0;
        w_ext    = '0;
        lane_sum = '0;
        for (int c = 0; c < col; c++) begin
            lane_sum = '0;
            for (int r = 0; r < row; r++) begin
                a_ext    = psum_bw'(l0_dout[bw*r +: bw]);
                w_ext    = psum_bw'(signed'(w[c][bw*r +: bw]));
                lane_sum = lane_sum + a_ext * w_ext;
            end
            dot_word[psum_bw*c +: psum_bw] = lane_sum;
        end
    end

    // Output FIFO. valid is a level indicator: high while the OFIFO holds a word;
    // the host consumes the head with ofifo_rd and there is no back-pressure path.
    logic [col*psum_bw-1:0] ofifo_dout;
    logic                   ofifo_empty;
    logic                   ofifo_push;

    assign ofifo_push = execute && l0_rd && !l0_empty;

    accel_core_fifo #(.W(col*psum_bw), .DEPTH(16)) u_ofifo (
        .clk   (clk),
        .reset (reset),
        .push  (ofifo_push),
        .pop   (ofifo_rd),
        .din   (dot_word),
        .dout  (ofifo_dout),
        .empty (ofifo_empty)
    );

    assign valid = !ofifo_empty;

    // Psum SRAM; contents survive reset so partial sums persist between kernel passes
    logic [col*psum_bw-1:0] pmem [num];
    logic [col*psum_bw-1:0] pmem_q;
    logic [col*psum_bw-1:0] pmem_wdata;

    assign pmem_wdata = ofifo_empty ? '0 : ofifo_dout;

    always_ff @(posedge clk) begin
        if (!reset && !cen_pmem && !wen_pmem) begin
            pmem[a_pmem] <= pmem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pmem_q <= '0;
        end else if (!cen_pmem && wen_pmem) begin
            pmem_q <= pmem[a_pmem];
        end
    end

    // Special-function stage
    logic [psum_bw-1:0] accum [col];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < col; c++) begin
                accum[c] <= '0;
            end
        end else if (acc) begin
            for (int c = 0; c < col; c++) begin
                accum[c] <= accum[c] + pmem_q[psum_bw*c +: psum_bw];
            end
        end
    end

    always_comb begin
        coreOut = '0;
        for (int c = 0; c < col; c++) begin
`ifdef ACCEL_CORE_RELU_EN
            coreOut[psum_bw*c +: psum_bw] = accum[c][psum_bw-1] ? '0 : accum[c];
`else
            coreOut[psum_bw*c +: psum_bw] = accum[c];
`endif
        end
    end
endmodule

// File: tb/tb_accel_core.sv
// Directed bench for accel_core: table of execute vectors plus hand sequences for
// accumulate, reset retention, FIFO boundaries and same-cycle load/execute.

module tb_accel_core;
    localparam logic [33:0] IDLE = 34'h1_0008_0000;

    typedef struct {
        logic [31:0] act;
        logic [31:0] wt;
        logic [15:0] lane;
    } vec_t;

    logic         clk;
    logic         reset;
    logic [33:0]  inst;
    logic [31:0]  D_xmem;
    logic         valid;
    logic [127:0] coreOut;

    int n_tests = 0;
    int n_fail  = 0;

    vec_t vecs [6];

    accel_core dut (
        .clk     (clk),
        .reset   (reset),
        .inst    (inst),
        .D_xmem  (D_xmem),
        .valid   (valid),
        .coreOut (coreOut)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic reset_dut(input int n);
        reset = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Driver tasks: each applies one instruction for one edge, then returns to idle
    task automatic step(input logic [33:0] i, input logic [31:0] d);
        inst   = i;
        D_xmem = d;
        @(posedge clk);
        #1;
        inst   = IDLE;
        D_xmem = '0;
    endtask

    task automatic xmem_write(input logic [10:0] addr, input logic [31:0] data);
        logic [33:0] i;
        i = IDLE; i[19] = 1'b0; i[18] = 1'b0; i[17:7] = addr;
        step(i, data);
    endtask

    task automatic xmem_read(input logic [10:0] addr);
        logic [33:0] i;
        i = IDLE; i[19] = 1'b0; i[18] = 1'b1; i[17:7] = addr;
        step(i, '0);
    endtask

    task automatic l0_write();
        logic [33:0] i;
        i = IDLE; i[2] = 1'b1;
        step(i, '0);
    endtask

    task automatic ififo_write(input logic [31:0] data);
        logic [33:0] i;
        i = IDLE; i[5] = 1'b1;
        step(i, data);
    endtask

    task automatic load_one();
        logic [33:0] i;
        i = IDLE; i[0] = 1'b1; i[4] = 1'b1;
        step(i, '0);
    endtask

    task automatic execute_one();
        logic [33:0] i;
        i = IDLE; i[1] = 1'b1; i[3] = 1'b1;
        step(i, '0);
    endtask

    task automatic load_and_execute();
        logic [33:0] i;
        i = IDLE; i[0] = 1'b1; i[4] = 1'b1; i[1] = 1'b1; i[3] = 1'b1;
        step(i, '0);
    endtask

    task automatic pmem_store(input logic [10:0] addr);
        logic [33:0] i;
        i = IDLE; i[32] = 1'b0; i[31] = 1'b0; i[30:20] = addr; i[6] = 1'b1;
        step(i, '0);
    endtask

    task automatic pmem_read(input logic [10:0] addr);
        logic [33:0] i;
        i = IDLE; i[32] = 1'b0; i[31] = 1'b1; i[30:20] = addr;
        step(i, '0);
    endtask

    task automatic acc_one();
        logic [33:0] i;
        i = IDLE; i[33] = 1'b1;
        step(i, '0);
    endtask

    // Scoreboard helpers
    function automatic logic [15:0] sfp(input logic [15:0] x);
`ifdef ACCEL_CORE_RELU_EN
        return x[15] ? 16'h0000 : x;
`else
        return x;
`endif
    endfunction

    function automatic logic [127:0] rep(input logic [15:0] v);
        return {8{v}};
    endfunction

    task automatic check(input string name, input logic [127:0] actual, input logic [127:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic run_vec(input vec_t v, input logic [10:0] addr, input string tag);
        logic [127:0] exp_q [$];
        reset_dut(2);
        xmem_write(addr, v.act);
        xmem_read(addr);
        l0_write();
        repeat (8) ififo_write(v.wt);
        repeat (8) load_one();
        check({tag, "_pre_valid"}, 128'(valid), 128'(0));
        execute_one();
        check({tag, "_valid"}, 128'(valid), 128'(1));
        pmem_store(addr);
        check({tag, "_popped"}, 128'(valid), 128'(0));
        pmem_read(addr);
        acc_one();
        exp_q.push_back(rep(sfp(v.lane)));
        check({tag, "_coreOut"}, coreOut, exp_q.pop_front());
    endtask

    initial begin
        logic [127:0] exp_word;
        logic [3:0]   v4;

        vecs[0] = '{act: 32'h1111_1111, wt: 32'h2222_2222, lane: 16'h0010};
        vecs[1] = '{act: 32'hFFFF_FFFF, wt: 32'hFFFF_FFFF, lane: 16'hFF88};
        vecs[2] = '{act: 32'h7654_3210, wt: 32'h1111_1111, lane: 16'h001C};
        vecs[3] = '{act: 32'hFFFF_FFFF, wt: 32'h8888_8888, lane: 16'hFC40};
        vecs[4] = '{act: 32'h0000_0000, wt: 32'h7777_7777, lane: 16'h0000};
        vecs[5] = '{act: 32'h1234_5678, wt: 32'h7F7F_7F7F, lane: 16'h005C};

        inst   = IDLE;
        D_xmem = '0;
        reset_dut(10);
        check("reset_valid", 128'(valid), 128'(0));
        check("reset_coreOut", coreOut, '0);

        for (int k = 0; k < 6; k++) begin
            run_vec(vecs[k], 11'(100 + k), $sformatf("vec%0d", k));
        end

        // Accumulate the same psum word over two edges
        reset_dut(2);
        xmem_write(0, 32'h1111_1111);
        xmem_read(0);
        l0_write();
        repeat (8) ififo_write(32'h2222_2222);
        repeat (8) load_one();
        execute_one();
        check("acc_valid", 128'(valid), 128'(1));
        pmem_store(5);
        check("acc_valid_fall", 128'(valid), 128'(0));
        pmem_read(5);
        acc_one();
        check("acc_first", coreOut, rep(16'h0010));
        acc_one();
        check("acc_second", coreOut, rep(16'h0020));

        // Long reset clears state but pmem keeps its contents
        reset_dut(10);
        check("rst2_valid", 128'(valid), 128'(0));
        check("rst2_coreOut", coreOut, '0);
        pmem_read(5);
        acc_one();
        check("rst2_pmem_kept", coreOut, rep(16'h0010));

        // Reset discards L0 contents; execute on empty L0 pushes nothing
        xmem_write(1, 32'h1111_1111);
        xmem_read(1);
        l0_write();
        reset_dut(2);
        execute_one();
        check("empty_exec_valid", 128'(valid), 128'(0));
        execute_one();
        check("empty_exec_valid2", 128'(valid), 128'(0));

        // pmem write with empty OFIFO stores zeros over old data
        pmem_store(5);
        pmem_read(5);
        acc_one();
        check("pmem_zero_store", coreOut, '0);

        // IFIFO overflow: 17th write dropped, 16 loads return wptr to 0
        reset_dut(2);
        for (int k = 0; k < 16; k++) begin
            v4 = 4'(k % 8);
            ififo_write({8{v4}});
        end
        ififo_write(32'h7777_7777);
        repeat (17) load_one();
        ififo_write(32'h3333_3333);
        load_one();
        xmem_write(2, 32'h1111_1111);
        xmem_read(2);
        l0_write();
        execute_one();
        check("ovf_valid", 128'(valid), 128'(1));
        pmem_store(8);
        pmem_read(8);
        acc_one();
        exp_word = '0;
        for (int c = 0; c < 8; c++) begin
            exp_word[16*c +: 16] = (c == 0) ? 16'd24 : 16'(8 * c);
        end
        check("ovf_columns", coreOut, exp_word);

        // Same-cycle load and execute uses the weights from before the edge
        reset_dut(2);
        repeat (8) ififo_write(32'h1111_1111);
        repeat (8) load_one();
        ififo_write(32'h7777_7777);
        xmem_write(3, 32'h1111_1111);
        xmem_read(3);
        l0_write();
        load_and_execute();
        check("ldex_valid", 128'(valid), 128'(1));
        pmem_store(9);
        pmem_read(9);
        acc_one();
        check("ldex_old_weights", coreOut, rep(16'h0008));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
